// File: rtl/ahb_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : ahb_pkg
// Brief    : Shared AHB-style bus encodings and lane-strobe helper.
// Revision : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } hsize_e;

    typedef enum logic [2:0] {
        BURST_SINGLE = 3'd0,
        BURST_INCR   = 3'd1,
        BURST_WRAP4  = 3'd2,
        BURST_INCR4  = 3'd3,
        BURST_WRAP8  = 3'd4,
        BURST_INCR8  = 3'd5,
        BURST_WRAP16 = 3'd6,
        BURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic {
        RESP_OKAY  = 1'b0,
        RESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } resp_state_e;

    // Byte lanes touched by a transfer of the given size at the given offset.
    function automatic logic [3:0] lane_strobe(input hsize_e size, input logic [1:0] addr);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr;
            SIZE_HALF: return 4'b0011 << {addr[1], 1'b0};
            SIZE_WORD: return 4'b1111;
            default:   return 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_responder_sram.sv
`default_nettype none
// ============================================================================
// Module   : sram_bytewise
// Brief    : DEPTH_WORDS x 32 memory with per-byte write enables, async read.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bytewise #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrIdx,
    input  logic [3:0]        i_wrStrb,
    input  logic [31:0]       i_wrData,
    input  logic [ADDR_W-1:0] i_rdIdx,
    output logic [31:0]       o_rdData
);

    for (genvar b = 0; b < 4; b++) begin : g_lane
        logic [7:0] r_mem [DEPTH_WORDS];

        always_ff @(posedge clk) begin
            if (i_wrEn && i_wrStrb[b]) begin
                r_mem[i_wrIdx] <= i_wrData[8*b +: 8];
            end
        end

        assign o_rdData[8*b +: 8] = r_mem[i_rdIdx];
    end

endmodule
`default_nettype wire

// File: rtl/ahb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : ahb_sram_responder
// Brief    : AHB-style responder backing a byte-writable SRAM window.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_responder
    import ahb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PSEL,
    input  logic [31:0] PADDR,
    input  logic        PWRITE,
    input  logic [1:0]  PSIZE,
    input  logic [1:0]  PTRANS,
    input  logic [2:0]  PBURST,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PRESP
);

    localparam int         c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_WAIT      = 4'(WAIT_STATES);
    localparam bit         c_ZERO_WAIT = (WAIT_STATES == 0);

    resp_state_e       r_state;
    logic [3:0]        r_waitCnt;
    logic              r_active;
    logic              r_write;
    hsize_e            r_size;
    logic [c_AW-1:0]   r_idx;
    logic [1:0]        r_lane;

    hsize_e            w_size;
    htrans_e           w_trans;
    logic              w_capture;
    logic              w_err;
    logic              w_commit;
    logic [3:0]        w_strb;
    logic              w_rdLoad;
    logic [c_AW-1:0]   w_rdIdx;
    logic [31:0]       w_memRd;
    logic [31:0]       w_rdMerged;
    logic              w_unused;

    assign w_size    = hsize_e'(PSIZE);
    assign w_trans   = htrans_e'(PTRANS);
    assign w_capture = PREADY && PSEL && (w_trans == TRANS_NONSEQ || w_trans == TRANS_SEQ);

    // Window is aligned to its own size, so range reduces to an upper-bit match.
    assign w_err = (w_size == SIZE_ILLEGAL)
                || (w_size == SIZE_HALF && PADDR[0])
                || (w_size == SIZE_WORD && PADDR[1:0] != 2'b00)
                || (PADDR[31:c_AW+2] != BASE_ADDR[31:c_AW+2]);

    assign w_commit = PREADY && r_active && r_write;
    assign w_strb   = lane_strobe(r_size, r_lane);

    // Zero-wait reads load at capture; waited reads load on the edge leaving WAIT.
    assign w_rdLoad = c_ZERO_WAIT ? (w_capture && !w_err && !PWRITE)
                                  : (r_state == ST_WAIT && r_waitCnt == 4'd1 && !r_write);
    assign w_rdIdx  = c_ZERO_WAIT ? PADDR[c_AW+1:2] : r_idx;

    assign w_unused = ^PBURST;

    sram_bytewise #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_AW)
    ) u_sram (
        .clk      (clk),
        .i_wrEn   (w_commit && !rst),
        .i_wrIdx  (r_idx),
        .i_wrStrb (w_strb),
        .i_wrData (PWDATA),
        .i_rdIdx  (w_rdIdx),
        .o_rdData (w_memRd)
    );

    always_comb begin
        w_rdMerged = w_memRd;
        for (int b = 0; b < 4; b++) begin
            if (w_commit && r_idx == w_rdIdx && w_strb[b]) begin
                w_rdMerged[8*b +: 8] = PWDATA[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            PREADY    <= 1'b1;
            PRESP     <= RESP_OKAY;
            PRDATA    <= 32'h0;
            r_active  <= 1'b0;
            r_waitCnt <= 4'd0;
            r_write   <= 1'b0;
            r_size    <= SIZE_BYTE;
            r_idx     <= '0;
            r_lane    <= 2'b00;
        end else begin
            if (w_rdLoad) begin
                PRDATA <= w_rdMerged;
            end
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    if (w_capture) begin
                        r_write <= PWRITE;
                        r_size  <= w_size;
                        r_idx   <= PADDR[c_AW+1:2];
                        r_lane  <= PADDR[1:0];
                        if (w_err) begin
                            r_state  <= ST_ERR1;
                            PREADY   <= 1'b0;
                            PRESP    <= RESP_ERROR;
                            r_active <= 1'b0;
                        end else begin
                            r_active <= 1'b1;
                            PRESP    <= RESP_OKAY;
                            if (c_ZERO_WAIT) begin
                                r_state <= ST_IDLE;
                                PREADY  <= 1'b1;
                            end else begin
                                r_state   <= ST_WAIT;
                                PREADY    <= 1'b0;
                                r_waitCnt <= c_WAIT;
                            end
                        end
                    end else begin
                        r_state  <= ST_IDLE;
                        PREADY   <= 1'b1;
                        PRESP    <= RESP_OKAY;
                        r_active <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    r_waitCnt <= r_waitCnt - 4'd1;
                    if (r_waitCnt == 4'd1) begin
                        r_state <= ST_IDLE;
                        PREADY  <= 1'b1;
                    end
                end
                ST_ERR1: begin
                    r_state <= ST_ERR2;
                    PREADY  <= 1'b1;
                    PRESP   <= RESP_ERROR;
                    if (!r_write) begin
                        PRDATA <= 32'h0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    PREADY   <= 1'b1;
                    PRESP    <= RESP_OKAY;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_sram_responder
// Brief    : Directed bench for three responders (0, 2 and 3 wait states).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_responder;

    localparam logic [31:0] c_BASE  = 32'h0000_2000;
    localparam int          c_DEPTH = 1024;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        write;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
    } op_t;

    typedef struct {
        logic        rdy;
        logic        resp;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [2:0]        psel, pwrite, pready, presp;
    logic [2:0][31:0]  paddr, pwdata, prdata;
    logic [2:0][1:0]   psize, ptrans;
    logic [2:0][2:0]   pburst;

    logic [2:0] chkEn = 3'b000;
    int         wsOf [3] = '{0, 2, 3};
    int         nChk = 0;
    int         nFail = 0;
    int         lowCnt [3];
    int         respCnt [3];
    logic [31:0] lastRd [3];

    op_t         ops [$];
    exp_t        expQ [3][$];
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    ahb_sram_responder #(.BASE_ADDR(c_BASE), .DEPTH_WORDS(c_DEPTH), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .PSEL(psel[0]), .PADDR(paddr[0]), .PWRITE(pwrite[0]),
        .PSIZE(psize[0]), .PTRANS(ptrans[0]), .PBURST(pburst[0]), .PWDATA(pwdata[0]),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PRESP(presp[0]));

    ahb_sram_responder #(.BASE_ADDR(c_BASE), .DEPTH_WORDS(c_DEPTH), .WAIT_STATES(2)) dut1 (
        .clk(clk), .rst(rst), .PSEL(psel[1]), .PADDR(paddr[1]), .PWRITE(pwrite[1]),
        .PSIZE(psize[1]), .PTRANS(ptrans[1]), .PBURST(pburst[1]), .PWDATA(pwdata[1]),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PRESP(presp[1]));

    ahb_sram_responder #(.BASE_ADDR(c_BASE), .DEPTH_WORDS(c_DEPTH), .WAIT_STATES(3)) dut2 (
        .clk(clk), .rst(rst), .PSEL(psel[2]), .PADDR(paddr[2]), .PWRITE(pwrite[2]),
        .PSIZE(psize[2]), .PTRANS(ptrans[2]), .PBURST(pburst[2]), .PWDATA(pwdata[2]),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PRESP(presp[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChk++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic addOp(input logic sel, input logic [1:0] trans, input logic [2:0] burst,
                         input logic write, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] data);
        op_t o;
        o.sel = sel; o.trans = trans; o.burst = burst; o.write = write;
        o.size = size; o.addr = addr; o.data = data;
        ops.push_back(o);
    endtask

    task automatic driveBus(input int d, input op_t o, input logic [31:0] wd);
        psel[d] = o.sel; ptrans[d] = o.trans; pburst[d] = o.burst; pwrite[d] = o.write;
        psize[d] = o.size; paddr[d] = o.addr; pwdata[d] = wd;
    endtask

    // Behavioural model: what the data phase of an accepted address phase must look like.
    task automatic modelAccept(input int d, input op_t o);
        logic        err;
        int          key, off, nb;
        logic [31:0] w;
        if (!o.sel || !o.trans[1]) begin
            expQ[d].push_back('{1'b1, 1'b0, 1'b0, 32'h0});
        end else begin
            err = (o.size == 2'b11) || (o.size == 2'b01 && o.addr % 2 != 0)
               || (o.size == 2'b10 && o.addr % 4 != 0)
               || (o.addr < c_BASE) || (o.addr >= c_BASE + 4 * c_DEPTH);
            if (err) begin
                expQ[d].push_back('{1'b0, 1'b1, 1'b0, 32'h0});
                expQ[d].push_back('{1'b1, 1'b1, !o.write, 32'h0});
            end else begin
                key = d * 65536 + int'((o.addr - c_BASE) / 4);
                w   = mdl.exists(key) ? mdl[key] : 32'h0;
                for (int k = 0; k < wsOf[d]; k++) expQ[d].push_back('{1'b0, 1'b0, 1'b0, 32'h0});
                if (o.write) begin
                    off = int'(o.addr % 4);
                    nb  = 1 << o.size;
                    for (int b = 0; b < 4; b++)
                        if (b >= off && b < off + nb) w[8*b +: 8] = o.data[8*b +: 8];
                    mdl[key] = w;
                    expQ[d].push_back('{1'b1, 1'b0, 1'b0, 32'h0});
                end else begin
                    expQ[d].push_back('{1'b1, 1'b0, 1'b1, w});
                end
            end
        end
    endtask

    task automatic runOps(input int d);
        int          i = 0;
        int          guard = 0;
        logic        rdy;
        logic [31:0] curData = 32'h0;
        op_t         idleOp;
        idleOp = '{1'b0, 2'b00, 3'b000, 1'b0, 2'b10, c_BASE, 32'h0};
        while (i < ops.size() && guard < 300) begin
            driveBus(d, ops[i], curData);
            @(negedge clk);
            rdy = pready[d];
            @(posedge clk); #1;
            if (rdy) begin
                modelAccept(d, ops[i]);
                curData = ops[i].data;
                i++;
            end
            guard++;
        end
        check($sformatf("accept-budget dut%0d", d), 32'(i), 32'(ops.size()));
        driveBus(d, idleOp, curData);
        guard = 0;
        while (expQ[d].size() != 0 && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("drain dut%0d", d), 32'(expQ[d].size()), 32'd0);
        expQ[d].delete();
        ops.delete();
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (chkEn[d]) begin
                e = '{1'b1, 1'b0, 1'b0, 32'h0};
                if (expQ[d].size() != 0) e = expQ[d].pop_front();
                check($sformatf("PREADY dut%0d", d), 32'(pready[d]), 32'(e.rdy));
                check($sformatf("PRESP dut%0d", d), 32'(presp[d]), 32'(e.resp));
                if (!pready[d]) lowCnt[d]++;
                if (presp[d]) respCnt[d]++;
                if (e.chk) begin
                    check($sformatf("PRDATA dut%0d", d), prdata[d], e.data);
                    lastRd[d] = prdata[d];
                end
            end
        end
    end

    initial begin
        op_t o;
        psel = '0; pwrite = '0; paddr = '0; pwdata = '0; psize = '0; ptrans = '0; pburst = '0;
        for (int d = 0; d < 3; d++) begin lowCnt[d] = 0; respCnt[d] = 0; lastRd[d] = 32'h0; end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset PREADY dut%0d", d), 32'(pready[d]), 32'd1);
            check($sformatf("reset PRESP dut%0d", d), 32'(presp[d]), 32'd0);
            check($sformatf("reset PRDATA dut%0d", d), prdata[d], 32'h0);
        end
        rst = 1'b0;
        chkEn = 3'b111;

        // Back-to-back word write then read (bypass)
        addOp(1, 2'b10, 3'b000, 1, 2'b10, 32'h2004, 32'hDEADBEEF);
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h2004, 32'h0);
        runOps(0);
        check("wr-rd bypass", lastRd[0], 32'hDEADBEEF);

        // Byte and halfword merges
        addOp(1, 2'b10, 3'b000, 1, 2'b10, 32'h2008, 32'h11223344);
        addOp(1, 2'b10, 3'b000, 1, 2'b00, 32'h200A, 32'h00AA0000);
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h2008, 32'h0);
        runOps(0);
        check("byte write", lastRd[0], 32'h11AA3344);
        addOp(1, 2'b10, 3'b000, 1, 2'b10, 32'h200C, 32'h0);
        addOp(1, 2'b10, 3'b000, 1, 2'b01, 32'h200E, 32'hCAFE0000);
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h200C, 32'h0);
        runOps(0);
        check("half write", lastRd[0], 32'hCAFE0000);

        // Error responses, unselected phase, and memory left untouched
        respCnt[0] = 0;
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h2002, 32'h0);
        addOp(1, 2'b10, 3'b000, 0, 2'b11, 32'h2000, 32'h0);
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h3000, 32'h0);
        addOp(1, 2'b10, 3'b000, 1, 2'b10, 32'h2006, 32'hFFFFFFFF);
        addOp(1, 2'b10, 3'b000, 1, 2'b10, 32'h1FFC, 32'hFFFFFFFF);
        addOp(0, 2'b10, 3'b000, 1, 2'b10, 32'h2004, 32'h00000000);
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h2004, 32'h0);
        runOps(0);
        check("error resp cycles", 32'(respCnt[0]), 32'd10);
        check("no write on error", lastRd[0], 32'hDEADBEEF);

        // Wait states: single read with WAIT_STATES=3
        addOp(1, 2'b10, 3'b000, 1, 2'b10, 32'h2040, 32'hA5A55A5A);
        runOps(2);
        lowCnt[2] = 0;
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h2040, 32'h0);
        runOps(2);
        check("wait cycles", 32'(lowCnt[2]), 32'd3);
        check("waited read", lastRd[2], 32'hA5A55A5A);

        // INCR4 burst with a BUSY after beat 2, then read back
        addOp(1, 2'b10, 3'b011, 1, 2'b10, 32'h2010, 32'h10101010);
        addOp(1, 2'b11, 3'b011, 1, 2'b10, 32'h2014, 32'h20202020);
        addOp(1, 2'b01, 3'b011, 1, 2'b10, 32'h2018, 32'hEEEEEEEE);
        addOp(1, 2'b11, 3'b011, 1, 2'b10, 32'h2018, 32'h30303030);
        addOp(1, 2'b11, 3'b011, 1, 2'b10, 32'h201C, 32'h40404040);
        addOp(1, 2'b10, 3'b011, 0, 2'b10, 32'h2010, 32'h0);
        addOp(1, 2'b11, 3'b011, 0, 2'b10, 32'h2014, 32'h0);
        addOp(1, 2'b11, 3'b011, 0, 2'b10, 32'h2018, 32'h0);
        runOps(2);
        check("burst beat 3", lastRd[2], 32'h30303030);
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h201C, 32'h0);
        runOps(2);
        check("burst beat 4", lastRd[2], 32'h40404040);

        // Reset mid-WAIT abandons the write (WAIT_STATES=2)
        addOp(1, 2'b10, 3'b000, 1, 2'b10, 32'h2030, 32'h12345678);
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h2030, 32'h0);
        runOps(1);
        check("pre-reset read", lastRd[1], 32'h12345678);
        chkEn[1] = 1'b0;
        o = '{1'b1, 2'b10, 3'b000, 1'b1, 2'b10, 32'h2030, 32'h0};
        driveBus(1, o, 32'h0);
        @(posedge clk); #1;
        psel[1] = 1'b0; ptrans[1] = 2'b00; pwdata[1] = 32'hFFFFFFFF;
        check("in WAIT before reset", 32'(pready[1]), 32'd0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("post-reset PREADY", 32'(pready[1]), 32'd1);
        check("post-reset PRESP", 32'(presp[1]), 32'd0);
        check("post-reset PRDATA", prdata[1], 32'h0);
        @(posedge clk); #1;
        chkEn[1] = 1'b1;
        addOp(1, 2'b10, 3'b000, 0, 2'b10, 32'h2030, 32'h0);
        runOps(1);
        check("word survives reset", lastRd[1], 32'h12345678);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
`default_nettype wire
